// File: rtl/interval_timer_cfg.sv
// Avalon-MM interval timer: programmable period, prescaler, one-shot/continuous
// modes, start/stop strobes and a coherent counter snapshot.
module interval_timer_cfg #(
  parameter int unsigned COUNTER_WIDTH  = 32,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h0000C34F,
  parameter int unsigned PRESCALE       = 1,
  parameter bit          START_AT_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam int CW = COUNTER_WIDTH;
  localparam logic [CW-1:0] DEF_P = DEFAULT_PERIOD[CW-1:0];
  localparam logic [15:0] PRE_RST = 16'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] per_q, per_d;
  logic [CW-1:0] snap_q, snap_d;
  logic [15:0]   pre_q, pre_d;
  logic [15:0]   rd_q, rd_d;
  logic          run_q, run_d;
  logic          to_q, to_d;
  logic          ito_q, ito_d;
  logic          cont_q, cont_d;
  logic          frc_q, frc_d;

  logic wr, wr_st, wr_ct, wr_pl, wr_ph, wr_sn;
  logic start, stop, tick, tmo;
  logic [31:0] per_x, snap_x;

  assign wr    = chipselect & ~write_n;
  assign wr_st = wr & (address == 3'd0);
  assign wr_ct = wr & (address == 3'd1);
  assign wr_pl = wr & (address == 3'd2);
  assign wr_ph = wr & (address == 3'd3);
  assign wr_sn = wr & ((address == 3'd4) | (address == 3'd5));
  assign start = wr_ct & writedata[2];
  assign stop  = wr_ct & writedata[3];

  // A pending forced reload suppresses the tick so no timeout can fire.
  assign tick = run_q & (pre_q == '0) & ~frc_q;
  assign tmo  = tick & (cnt_q == '0);

  assign per_x  = 32'(per_q);
  assign snap_x = 32'(snap_q);

  always_comb begin
    pre_d = pre_q;
    if (!run_q || pre_q == '0) pre_d = PRE_RST;
    else                       pre_d = pre_q - 16'd1;
    if (frc_q || stop) pre_d = PRE_RST;

    cnt_d = cnt_q;
    if (frc_q)     cnt_d = per_q;
    else if (tick) cnt_d = (cnt_q == '0) ? per_q : cnt_q - 1'b1;

    to_d = to_q;
    if (tmo)        to_d = 1'b1;
    else if (wr_st) to_d = 1'b0;

    ito_d  = wr_ct ? writedata[0] : ito_q;
    cont_d = wr_ct ? writedata[1] : cont_q;

    run_d = run_q;
    if (tmo && !cont_q) run_d = 1'b0;
    if (start)          run_d = 1'b1;
    if (stop)           run_d = 1'b0;

    per_d = per_q;
    if (wr_pl) per_d[15:0]    = writedata;
    if (wr_ph) per_d[CW-1:16] = writedata[CW-17:0];
    frc_d = wr_pl | wr_ph;

    snap_d = wr_sn ? cnt_q : snap_q;
  end

  always_comb begin
    rd_d = '0;
    case (address)
      3'd0:    rd_d = {14'd0, run_q, to_q};
      3'd1:    rd_d = {14'd0, cont_q, ito_q};
      3'd2:    rd_d = per_x[15:0];
      3'd3:    rd_d = per_x[31:16];
      3'd4:    rd_d = snap_x[15:0];
      3'd5:    rd_d = snap_x[31:16];
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= DEF_P;
      per_q  <= DEF_P;
      snap_q <= '0;
      pre_q  <= PRE_RST;
      rd_q   <= '0;
      run_q  <= START_AT_RESET;
      cont_q <= START_AT_RESET;
      to_q   <= 1'b0;
      ito_q  <= 1'b0;
      frc_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      snap_q <= snap_d;
      pre_q  <= pre_d;
      rd_q   <= rd_d;
      run_q  <= run_d;
      cont_q <= cont_d;
      to_q   <= to_d;
      ito_q  <= ito_d;
      frc_q  <= frc_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = to_q & ito_q;

endmodule

// File: tb/tb_interval_timer_cfg.sv
// Bench for interval_timer_cfg: two instances (prescale 1 auto-start and
// prescale 4 stopped) checked every cycle against a tick-arithmetic model.
module tb_interval_timer_cfg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'd0;
  logic [15:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit armed   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  interval_timer_cfg #(.PRESCALE(1), .START_AT_RESET(1'b1)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a), .irq(irq_a));

  interval_timer_cfg #(.PRESCALE(4), .START_AT_RESET(1'b0)) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b), .irq(irq_b));

  function automatic longint ps(int k);
    return (k == 0) ? 64'd1 : 64'd4;
  endfunction

  // Counter value after t = cyc/p ticks from a segment starting at base.
  function automatic longint cnt_of(longint base, longint cy, longint per, longint p);
    longint t;
    t = cy / p;
    if (t <= base) return base - t;
    return per - ((t - base - 1) % (per + 1));
  endfunction

  longint   m_base[2], m_cyc[2], m_per[2], m_snap[2];
  bit       m_run[2], m_to[2], m_ito[2], m_cont[2], m_frc[2];
  logic [15:0] m_rd[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin : mdl
      longint cnow, c2, t, p;
      bit we, tmo, old_cont, stp, sta;
      if (reset) begin
        m_base[k] = 64'hC34F; m_per[k] = 64'hC34F; m_cyc[k] = 0;
        m_snap[k] = 0; m_run[k] = (k == 0); m_cont[k] = (k == 0);
        m_to[k] = 0; m_ito[k] = 0; m_frc[k] = 0; m_rd[k] = 16'd0;
        armed = 1'b1;
      end else begin
        p = ps(k);
        we = chipselect && !write_n;
        cnow = cnt_of(m_base[k], m_cyc[k], m_per[k], p);
        case (address)
          3'd0: m_rd[k] = {14'd0, m_run[k], m_to[k]};
          3'd1: m_rd[k] = {14'd0, m_cont[k], m_ito[k]};
          3'd2: m_rd[k] = 16'(m_per[k]);
          3'd3: m_rd[k] = 16'(m_per[k] >> 16);
          3'd4: m_rd[k] = 16'(m_snap[k]);
          3'd5: m_rd[k] = 16'(m_snap[k] >> 16);
          default: m_rd[k] = 16'd0;
        endcase
        c2 = m_cyc[k] + 1;
        t = c2 / p;
        tmo = m_run[k] && !m_frc[k] && (c2 % p == 0) && (t > m_base[k])
              && ((t - m_base[k] - 1) % (m_per[k] + 1) == 0);
        old_cont = m_cont[k];
        if (m_frc[k]) begin
          m_base[k] = m_per[k]; m_cyc[k] = 0;
        end else if (m_run[k]) begin
          m_cyc[k] = c2;
        end
        if (tmo) m_to[k] = 1;
        else if (we && address == 3'd0) m_to[k] = 0;
        stp = we && address == 3'd1 && writedata[3];
        sta = we && address == 3'd1 && writedata[2];
        if (we && address == 3'd1) begin
          m_ito[k] = writedata[0]; m_cont[k] = writedata[1];
        end
        if (stp || (!sta && tmo && !old_cont)) begin
          m_base[k] = cnt_of(m_base[k], m_cyc[k], m_per[k], p);
          m_cyc[k] = 0; m_run[k] = 0;
        end else if (sta && !m_run[k]) begin
          m_run[k] = 1; m_cyc[k] = 0;
        end
        if (we && address == 3'd2)
          m_per[k] = (m_per[k] & 64'hFFFF0000) | longint'(writedata);
        if (we && address == 3'd3)
          m_per[k] = (m_per[k] & 64'h0000FFFF) | (longint'(writedata) << 16);
        m_frc[k] = we && (address == 3'd2 || address == 3'd3);
        if (we && (address == 3'd4 || address == 3'd5)) m_snap[k] = cnow;
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("model_rd_a", rd_a, m_rd[0]);
      chk("model_irq_a", {15'd0, irq_a}, {15'd0, m_to[0] & m_ito[0]});
      chk("model_rd_b", rd_b, m_rd[1]);
      chk("model_irq_b", {15'd0, irq_b}, {15'd0, m_to[1] & m_ito[1]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
  endtask

  task automatic wr_at(input int t, input logic [2:0] a, input logic [15:0] d);
    while (cyc < t - 1) step();
    wr(a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    address = a;
    step();
    address = 3'd0;
  endtask

  initial begin
    int s, t, u, x, t0;
    repeat (3) step();
    chk("rst_rd_a", rd_a, 16'h0);
    chk("rst_irq_a", {15'd0, irq_a}, 16'h0);
    reset = 1'b0;

    // default period, auto-start: first timeout on the 50000th edge
    t0 = cyc;
    while (cyc < t0 + 50000) step();
    chk("a_pre_to", rd_a, 16'h2);
    step();
    chk("a_to", rd_a, 16'h3);
    chk("a_irq_masked", {15'd0, irq_a}, 16'h0);
    chk("b_idle", rd_b, 16'h0);
    wr(3'd1, 16'h0001);
    chk("a_irq_en", {15'd0, irq_a}, 16'h1);
    rd(3'd1);
    chk("a_ctrl", rd_a, 16'h1);

    // period 9, continuous
    wr(3'd1, 16'h0009);
    wr(3'd2, 16'h0009);
    wr(3'd3, 16'h0000);
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0007);
    s = cyc;
    while (cyc < s + 9) step();
    chk("a_irq_pre10", {15'd0, irq_a}, 16'h0);
    step();
    chk("a_irq_10", {15'd0, irq_a}, 16'h1);
    wr_at(s + 15, 3'd0, 16'h0);
    chk("a_clr", {15'd0, irq_a}, 16'h0);
    wr_at(s + 30, 3'd0, 16'h0);
    chk("a_clr_vs_to", {15'd0, irq_a}, 16'h1);
    while (cyc < s + 39) step();
    chk("b_pre40", {15'd0, irq_b}, 16'h0);
    step();
    chk("b_to_40", {15'd0, irq_b}, 16'h1);

    // period 2, one-shot
    wr(3'd1, 16'h0008);
    wr(3'd2, 16'h0002);
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0005);
    s = cyc;
    while (cyc < s + 12) step();
    chk("b_os_pre", rd_b, 16'h2);
    chk("b_os_irq", {15'd0, irq_b}, 16'h1);
    step();
    chk("b_os_st", rd_b, 16'h1);
    repeat (30) step();
    chk("b_os_once", rd_b, 16'h1);
    chk("a_os_st", rd_a, 16'h1);
    wr(3'd4, 16'h0);
    rd(3'd4);
    chk("b_os_cnt", rd_b, 16'h2);
    rd(3'd5);
    chk("b_os_cnth", rd_b, 16'h0);

    // snapshot at period 0x1_0000
    wr(3'd2, 16'h0000);
    wr(3'd3, 16'h0001);
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0007);
    t = cyc;
    wr(3'd4, 16'hABCD);
    rd(3'd4);
    chk("a_snapl", rd_a, 16'h0000);
    chk("b_snapl", rd_b, 16'h0000);
    rd(3'd5);
    chk("a_snaph", rd_a, 16'h0001);
    chk("b_snaph", rd_b, 16'h0001);
    repeat (7) step();
    rd(3'd4);
    chk("a_snapl_stable", rd_a, 16'h0000);
    rd(3'd5);
    chk("a_snaph_stable", rd_a, 16'h0001);
    u = cyc + 1;
    wr(3'd5, 16'h0);
    rd(3'd4);
    chk("a_snap2", rd_a, 16'(32'h10000 - (u - 1 - t)));
    chk("b_snap2", rd_b, 16'(32'h10000 - (u - 1 - t) / 4));

    // start|stop together stops and freezes
    x = cyc + 1;
    wr(3'd1, 16'h000C);
    rd(3'd0);
    chk("a_stopped", rd_a, 16'h0);
    chk("b_stopped", rd_b, 16'h0);
    repeat (10) step();
    wr(3'd4, 16'h0);
    rd(3'd4);
    chk("a_frozen", rd_a, 16'(32'h10000 - (x - t)));
    chk("b_frozen", rd_b, 16'(32'h10000 - (x - t) / 4));
    wr(3'd2, 16'h0005);
    step();
    wr(3'd4, 16'h0);
    rd(3'd4);
    chk("a_reload_l", rd_a, 16'h0005);
    rd(3'd5);
    chk("a_reload_h", rd_a, 16'h0001);
    rd(3'd0);
    chk("a_reload_run", rd_a, 16'h0);

    wr(3'd6, 16'hFFFF);
    rd(3'd6);
    chk("a_addr6", rd_a, 16'h0);
    rd(3'd7);
    chk("b_addr7", rd_b, 16'h0);

    // reset mid-count
    wr(3'd3, 16'h0000);
    wr(3'd2, 16'h0003);
    wr(3'd1, 16'h0007);
    repeat (20) step();
    rd(3'd0);
    chk("a_pre_rst", rd_a, 16'h3);
    chk("b_pre_rst", rd_b, 16'h3);
    reset = 1'b1;
    step();
    chk("a_rst_rd", rd_a, 16'h0);
    chk("a_rst_irq", {15'd0, irq_a}, 16'h0);
    chk("b_rst_rd", rd_b, 16'h0);
    chk("b_rst_irq", {15'd0, irq_b}, 16'h0);
    reset = 1'b0;
    wr(3'd4, 16'h0);
    rd(3'd4);
    chk("a_rst_cnt", rd_a, 16'hC34F);
    chk("b_rst_cnt", rd_b, 16'hC34F);
    rd(3'd5);
    chk("a_rst_cnth", rd_a, 16'h0);
    rd(3'd0);
    chk("a_rst_st", rd_a, 16'h2);
    chk("b_rst_st", rd_b, 16'h0);
    rd(3'd1);
    chk("a_rst_ctl", rd_a, 16'h2);
    chk("b_rst_ctl", rd_b, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
